// File: rtl/pwm_deadband_pkg.sv
// rtl/pwm_deadband_pkg.sv - shared state encodings, reset defines and bus addresses for the dead-band stage
// Purpose: common definitions imported by pwm_db_chan and pwm_deadband.
//   db_state_e      : per-channel FSM state (DIS, LOW, DEAD_R, HIGH, DEAD_F)
//   PWM_DB_DT_ADDR  : dead-time register address
//   PWM_DB_EN_ADDR  : channel-enable register address
`ifndef RstEnable
`define RstEnable 1'b0
`endif
`ifndef ZeroWord
`define ZeroWord 32'h00000000
`endif

package pwm_deadband_pkg;

  // Peripheral address map entries owned by the dead-band stage.
  localparam logic [31:0] PWM_DB_DT_ADDR = 32'h60200000;
  localparam logic [31:0] PWM_DB_EN_ADDR = 32'h60210000;

  typedef enum logic [2:0] {
    ST_DIS    = 3'd0,
    ST_LOW    = 3'd1,
    ST_DEAD_R = 3'd2,
    ST_HIGH   = 3'd3,
    ST_DEAD_F = 3'd4
  } db_state_e;

endpackage

// File: rtl/pwm_db_chan.sv
// rtl/pwm_db_chan.sv - one complementary gate-drive channel with dead-time insertion
// Purpose: turns one PWM bit into a non-overlapping hi/lo pair.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   i_en   in   channel enable (0 forces DIS)
//   i_pwm  in   raw PWM level for this channel
//   i_dt   in   current dead-time setting (cycles)
//   o_hi   out  high-side drive, registered
//   o_lo   out  low-side drive, registered
module pwm_db_chan
  import pwm_deadband_pkg::*;
#(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic            i_pwm,
  input  logic [DT_W-1:0] i_dt,
  output logic            o_hi,
  output logic            o_lo
);

  localparam logic [DT_W-1:0] CNT_ONE = DT_W'(1);

  db_state_e       r_state, w_state_nx;
  logic [DT_W-1:0] r_cnt, w_cnt_nx;
  logic [DT_W-1:0] r_dt_lat, w_dt_lat_nx;
  logic            r_hi, r_lo;
  logic            w_dt_zero;

  assign w_dt_zero = (i_dt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RstEnable) begin
      r_state  <= ST_DIS;
      r_cnt    <= '0;
      r_dt_lat <= '0;
      r_hi     <= 1'b0;
      r_lo     <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_dt_lat <= w_dt_lat_nx;
      // Drive flops follow the state being entered, so they always
      // match the decode of r_state and can never both be high.
      r_hi     <= (w_state_nx == ST_HIGH);
      r_lo     <= (w_state_nx == ST_LOW);
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_dt_lat_nx = r_dt_lat;
    if (!i_en) begin
      w_state_nx = ST_DIS;
    end else begin
      case (r_state)
        ST_DIS: w_state_nx = ST_LOW;
        ST_LOW: begin
          if (i_pwm) begin
            if (w_dt_zero) begin
              w_state_nx = ST_HIGH;
            end else begin
              w_state_nx  = ST_DEAD_R;
              w_cnt_nx    = CNT_ONE;
              w_dt_lat_nx = i_dt;
            end
          end
        end
        ST_DEAD_R: begin
          // Abort is safe: hi has not been driven yet in this interval.
          if (!i_pwm)                  w_state_nx = ST_LOW;
          else if (r_cnt >= r_dt_lat)  w_state_nx = ST_HIGH;
          else                         w_cnt_nx   = r_cnt + CNT_ONE;
        end
        ST_HIGH: begin
          if (!i_pwm) begin
            if (w_dt_zero) begin
              w_state_nx = ST_LOW;
            end else begin
              w_state_nx  = ST_DEAD_F;
              w_cnt_nx    = CNT_ONE;
              w_dt_lat_nx = i_dt;
            end
          end
        end
        ST_DEAD_F: begin
          if (i_pwm)                   w_state_nx = ST_HIGH;
          else if (r_cnt >= r_dt_lat)  w_state_nx = ST_LOW;
          else                         w_cnt_nx   = r_cnt + CNT_ONE;
        end
        default: w_state_nx = ST_DIS;
      endcase
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/pwm_deadband.sv
// rtl/pwm_deadband.sv - complementary gate-drive stage with programmable dead time for the 4-channel PWM
// Purpose: register decode for dead time / channel enable, optional input
//   synchronizer, and NCH pwm_db_chan instances.
// Optional feature macro: PWM_DB_SYNC_EN (2-flop synchronizer on pwm_in).
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   we_i        in   bus write strobe
//   write_addr  in   bus write address
//   write_data  in   bus write data
//   pwm_in      in   raw PWM from the upstream PWM block
//   pwm_hi      out  high-side gate drive, registered
//   pwm_lo      out  low-side gate drive, registered
module pwm_deadband
  import pwm_deadband_pkg::*;
#(
  parameter int          DT_W    = 8,
  parameter int          NCH     = 4,
  parameter logic [31:0] DT_ADDR = PWM_DB_DT_ADDR,
  parameter logic [31:0] EN_ADDR = PWM_DB_EN_ADDR
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we_i,
  input  logic [31:0]    write_addr,
  input  logic [31:0]    write_data,
  input  logic [NCH-1:0] pwm_in,
  output logic [NCH-1:0] pwm_hi,
  output logic [NCH-1:0] pwm_lo
);

  logic [DT_W-1:0] r_dt;
  logic [NCH-1:0]  r_en;
  logic [NCH-1:0]  w_pwm;
  logic            w_unused_wdata;

  // Only the low bits of the write data are architected.
  assign w_unused_wdata = ^write_data;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RstEnable) begin
      r_dt <= '0;
      r_en <= '0;
    end else if (we_i) begin
      if (write_addr == DT_ADDR) r_dt <= write_data[DT_W-1:0];
      if (write_addr == EN_ADDR) r_en <= write_data[NCH-1:0];
    end
  end

`ifdef PWM_DB_SYNC_EN
  logic [NCH-1:0] r_sync1, r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == `RstEnable) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pwm = r_sync2;
`else
  assign w_pwm = pwm_in;
`endif

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    pwm_db_chan #(
      .DT_W (DT_W)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .i_en  (r_en[gi]),
      .i_pwm (w_pwm[gi]),
      .i_dt  (r_dt),
      .o_hi  (pwm_hi[gi]),
      .o_lo  (pwm_lo[gi])
    );
  end

endmodule

// File: doc/pwm_deadband.md
Name: pwm_deadband

Overview:
- Downstream stage of the 4-channel PWM peripheral. Consumes its pwm_out[3:0] and turns each channel into a complementary gate-drive pair (hi/lo).
- Inserts a programmable dead time so that hi and lo are never asserted together.
- Configured over the same write-only peripheral bus (we_i/write_addr/write_data) that the PWM block uses.
- Sits between the PWM block and the SoC top-level pads.

Parameters:
- DT_W, 8, width of the dead-time count; supports a maximum dead time of 2^DT_W-1 cycles.
- NCH, 4, number of channels; must match the PWM output width.
- DT_ADDR, 32'h60200000, address of the dead-time register.
- EN_ADDR, 32'h60210000, address of the channel-enable register.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (`RstEnable == 1'b0)
- we_i  in  1  bus write strobe
- write_addr  in  32  bus write address
- write_data  in  32  bus write data
- pwm_in  in  NCH  raw PWM from the upstream PWM block
- pwm_hi  out  NCH  high-side gate drive, registered
- pwm_lo  out  NCH  low-side gate drive, registered

Behaviour:
- Reset (async assert, sync release):
  - dt_reg=0, en_reg=0.
  - All channels in state DIS.
  - pwm_hi=0, pwm_lo=0.
- Register writes:
  - When we_i=1 and write_addr==DT_ADDR: dt_reg <= write_data[DT_W-1:0].
  - When we_i=1 and write_addr==EN_ADDR: en_reg <= write_data[NCH-1:0].
  - Any other address leaves both registers unchanged. Registers are not cleared on non-matching writes.
  - There is no read path.
- Per-channel FSM (independent, one per channel). States: DIS, LOW, DEAD_R, HIGH, DEAD_F. Per-channel cnt[DT_W-1:0] and dt_lat[DT_W-1:0].
- Outputs decode from registered state:
  - LOW: lo=1, hi=0.
  - HIGH: hi=1, lo=0.
  - DIS, DEAD_R, DEAD_F: both outputs 0.
- State transitions (evaluated each clk; en = en_reg[i], in = pwm_in[i]):
  - Any state with en=0 -> DIS on the next edge. This has priority over all other transitions.
  - DIS & en=1 -> LOW.
  - LOW & in=1:
    - dt_reg==0 -> HIGH directly (bypass).
    - otherwise -> DEAD_R, with cnt<=1 and dt_lat<=dt_reg.
  - DEAD_R & in=0 -> LOW (abort; safe because hi was never driven).
  - DEAD_R & in=1 & cnt>=dt_lat -> HIGH. Otherwise cnt<=cnt+1.
  - HIGH & in=0: mirror of LOW & in=1, into DEAD_F (or directly LOW when dt_reg==0).
  - DEAD_F & in=1 -> HIGH (abort).
  - DEAD_F & in=0 & cnt>=dt_lat -> LOW. Otherwise cnt<=cnt+1.
- Timing guarantees:
  - With dt_reg=N>0, both outputs are low for exactly N cycles between complementary transitions.
  - Latency from a pwm_in edge to the first output change is 1 cycle (the outgoing side drops).
  - The incoming side rises N+1 cycles after the pwm_in edge.
- dt_reg changes mid-dead-time do not affect the channel in progress, because it uses dt_lat. The new value applies from the next dead interval.
- Invariant: hi & lo == 0 on every channel in every cycle, including across reset and disable.
- cnt never wraps: the maximum is dt_lat ≤ 2^DT_W-1.
- Reset mid-operation drops both outputs immediately (asynchronously).

Optional Feature:
- Macro: PWM_DB_SYNC_EN.
- Defined: pwm_in passes through a 2-flop synchronizer per channel, reset to 0, before reaching the FSM. All input-to-output latencies grow by 2 cycles. Use this when pwm_in comes from another clock domain or a pad.
- Undefined: pwm_in feeds the FSM directly. This is the case for the same-clock PWM block.

Decomposition:
- Shared package/defines:
  - FSM state encodings (3 bits: DIS, LOW, DEAD_R, HIGH, DEAD_F).
  - DT_ADDR and EN_ADDR constants, placed alongside the other peripheral addresses.
  - Reuse the existing `RstEnable/`ZeroWord defines.
- Sub-module: pwm_db_chan holds one channel's FSM, cnt and dt_lat, and its hi/lo flops. It is instantiated NCH times with a generate loop.
- The top level keeps the register decode and the optional synchronizer.

Test Plan:
1. Reset then no writes; pwm_in toggling -> pwm_hi=pwm_lo=0 throughout (DIS).
2. Write EN=4'hF, DT=3; pwm_in[0] 0->1 at cycle t -> lo[0] falls at t+1, hi[0] rises at t+4. pwm_in 1->0 at u -> hi[0] falls at u+1, lo[0] rises at u+4.
3. DT=0, EN=4'h1; pwm_in[0] toggles every cycle -> hi/lo swap on the same edge, 1-cycle latency, never both 1.
4. DT=5; pwm_in[1] high pulse of 2 cycles -> hi[1] never asserts; lo[1] is low for 2 cycles, then reasserts (abort path).
5. DT=4, channel in DEAD_R; write DT=10 -> current interval still 4 cycles; next interval is 10 cycles.
6. Mid-HIGH, write EN=0 -> hi drops next cycle and the channel stays in DIS; async rst low mid-DEAD_F -> both outputs 0 immediately. Checker asserts hi&lo==0 every cycle.
